// File: rtl/sensor_pkg.sv
// Shared definitions for the vehicle-detector front end: channel state
// encoding, default filter/watchdog limits and the counter packing helper.
package sensor_pkg;

  // Per-channel occupancy state
  typedef enum logic [1:0] {
    S_OFF   = 2'd0,
    S_ON    = 2'd1,
    S_FAULT = 2'd2
  } ch_state_e;

  // Default debounce threshold (commit after limit+1 mismatching cycles)
  localparam int unsigned DefFilterLimit = 10;

  // Default continuous-presence limit before a channel is declared stuck
  localparam int unsigned DefStuckLimit = 100000;

  // LSB of channel ch's counter inside the packed arrival_cnt bus
  function automatic int unsigned cnt_lsb(input int unsigned ch, input int unsigned cnt_w);
    return ch * cnt_w;
  endfunction

endpackage

// File: rtl/sensor_channel.sv
// One detector channel: polarity normalisation, 2-flop synchroniser,
// debounce filter, OFF/ON/FAULT state machine with stuck-sensor watchdog,
// sticky service request and saturating arrival counter. Every output is
// driven straight from a flop.
module sensor_channel
  import sensor_pkg::*;
#(
  parameter logic        ActiveLow   = 1'b1,
  parameter int unsigned FilterLimit = DefFilterLimit,
  parameter int unsigned StuckLimit  = DefStuckLimit,
  parameter int unsigned CntW        = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            raw_i,
  input  logic            req_clr_i,
  input  logic            cnt_clr_i,
  output logic            present_o,
  output logic            pulse_o,
  output logic            request_o,
  output logic [CntW-1:0] cnt_o,
  output logic            fault_o
);

  localparam int unsigned DcntW  = (FilterLimit > 0) ? $clog2(FilterLimit + 1) : 1;
  localparam int unsigned TimerW = (StuckLimit > 0) ? $clog2(StuckLimit + 1) : 1;

  localparam logic [DcntW-1:0]  DcntMax    = DcntW'(FilterLimit);
  localparam logic [TimerW-1:0] TimerFault = TimerW'(StuckLimit - 1);
  localparam logic [TimerW-1:0] TimerMax   = TimerW'(StuckLimit);
  localparam logic [CntW-1:0]   CntMax     = '1;

  logic norm;
  logic sync1_q, sync2_q;

  logic             stable_q, stable_d;
  logic [DcntW-1:0] dcnt_q, dcnt_d;

  ch_state_e         state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic              pulse_d;
  logic              fault_entry;

  logic            present_q, pulse_q, request_q, fault_q;
  logic            request_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Polarity is fixed per channel, so flip before the synchroniser
  assign norm = raw_i ^ ActiveLow;

  // Two-flop synchroniser on the normalised input
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= norm;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: commit a change only after FilterLimit+1 consecutive mismatches
  always_comb begin
    stable_d = stable_q;
    dcnt_d   = '0;
    if (sync2_q != stable_q) begin
      if (dcnt_q == DcntMax) begin
        stable_d = sync2_q;
      end else begin
        dcnt_d = dcnt_q + DcntW'(1);
      end
    end
  end

  // Debounce state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable_q <= 1'b0;
      dcnt_q   <= '0;
    end else begin
      stable_q <= stable_d;
      dcnt_q   <= dcnt_d;
    end
  end

  // Occupancy FSM and stuck watchdog next-state
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    pulse_d     = 1'b0;
    fault_entry = 1'b0;
    unique case (state_q)
      S_OFF: begin
        // In S_OFF stable is known low until it rises, so a level test is an edge test
        if (stable_q) begin
          state_d = S_ON;
          pulse_d = 1'b1;
          timer_d = '0;
        end
      end
      S_ON: begin
        if (!stable_q) begin
          state_d = S_OFF;
        end else if (timer_q == TimerFault) begin
          state_d     = S_FAULT;
          fault_entry = 1'b1;
        end else if (timer_q != TimerMax) begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      S_FAULT: begin
        // Masked until the sensor actually releases; no arrival is reported
        if (!stable_q) begin
          state_d = S_OFF;
        end
      end
      default: begin
        state_d = S_OFF;
      end
    endcase
  end

  // FSM state and watchdog timer register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_OFF;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  // Sticky request: fault entry beats a new arrival, which beats a clear
  always_comb begin
    request_d = request_q;
    if (req_clr_i) begin
      request_d = 1'b0;
    end
    if (pulse_d) begin
      request_d = 1'b1;
    end
    if (fault_entry) begin
      request_d = 1'b0;
    end
  end

  // Saturating arrival counter; a clear coincident with an arrival lands on 1
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr_i) begin
      cnt_d = pulse_d ? CntW'(1) : '0;
    end else if (pulse_d && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Output registers, loaded from next-state so they track the FSM edge-for-edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      present_q <= 1'b0;
      pulse_q   <= 1'b0;
      request_q <= 1'b0;
      fault_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      present_q <= (state_d == S_ON);
      pulse_q   <= pulse_d;
      request_q <= request_d;
      fault_q   <= (state_d == S_FAULT);
      cnt_q     <= cnt_d;
    end
  end

  assign present_o = present_q;
  assign pulse_o   = pulse_q;
  assign request_o = request_q;
  assign fault_o   = fault_q;
  assign cnt_o     = cnt_q;

endmodule

// File: rtl/sensor_array_input.sv
// Multi-channel vehicle-detector front end: one sensor_channel per input,
// outputs gathered into per-channel bit vectors and a packed counter bus.
module sensor_array_input
  import sensor_pkg::*;
#(
  parameter int unsigned       N_CH            = 4,
  parameter logic [N_CH-1:0]   ACTIVE_LOW_MASK = {N_CH{1'b1}},
  parameter int unsigned       FILTER_LIMIT    = DefFilterLimit,
  parameter int unsigned       STUCK_LIMIT     = DefStuckLimit,
  parameter int unsigned       CNT_W           = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH-1:0]       sensor_raw,
  input  logic [N_CH-1:0]       req_clr,
  input  logic                  cnt_clr,
  output logic [N_CH-1:0]       present,
  output logic [N_CH-1:0]       arrival_pulse,
  output logic [N_CH-1:0]       request,
  output logic [N_CH*CNT_W-1:0] arrival_cnt,
  output logic [N_CH-1:0]       fault
);

  logic [CNT_W-1:0] cnt [N_CH];

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    sensor_channel #(
      .ActiveLow   (ACTIVE_LOW_MASK[i]),
      .FilterLimit (FILTER_LIMIT),
      .StuckLimit  (STUCK_LIMIT),
      .CntW        (CNT_W)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .raw_i     (sensor_raw[i]),
      .req_clr_i (req_clr[i]),
      .cnt_clr_i (cnt_clr),
      .present_o (present[i]),
      .pulse_o   (arrival_pulse[i]),
      .request_o (request[i]),
      .cnt_o     (cnt[i]),
      .fault_o   (fault[i])
    );
  end

  // Pack per-channel counters, channel i at [i*CNT_W +: CNT_W]
  always_comb begin
    arrival_cnt = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      arrival_cnt[cnt_lsb(i, CNT_W) +: CNT_W] = cnt[i];
    end
  end

endmodule

// File: tb/tb_sensor_array_input.sv
// Scoreboard bench for sensor_array_input. The stimulus process advances a
// behavioural model one clock per step and queues the expected outputs; an
// independent monitor pops one entry after every rising edge and compares.
module tb_sensor_array_input;

  localparam int unsigned N_CH = 4;
  localparam int unsigned FL   = 3;
  localparam int unsigned SL   = 50;
  localparam int unsigned CW   = 4;
  localparam logic [N_CH-1:0] MASK = 4'b1011;
  localparam int CNT_MAX = (1 << CW) - 1;

  typedef struct packed {
    logic [N_CH-1:0]    present;
    logic [N_CH-1:0]    pulse;
    logic [N_CH-1:0]    request;
    logic [N_CH-1:0]    fault;
    logic [N_CH*CW-1:0] cnt;
  } exp_t;

  logic                 clk;
  logic                 rst;
  logic [N_CH-1:0]      sensor_raw;
  logic [N_CH-1:0]      req_clr;
  logic                 cnt_clr;
  logic [N_CH-1:0]      present;
  logic [N_CH-1:0]      arrival_pulse;
  logic [N_CH-1:0]      request;
  logic [N_CH*CW-1:0]   arrival_cnt;
  logic [N_CH-1:0]      fault;

  sensor_array_input #(
    .N_CH            (N_CH),
    .ACTIVE_LOW_MASK (MASK),
    .FILTER_LIMIT    (FL),
    .STUCK_LIMIT     (SL),
    .CNT_W           (CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .sensor_raw    (sensor_raw),
    .req_clr       (req_clr),
    .cnt_clr       (cnt_clr),
    .present       (present),
    .arrival_pulse (arrival_pulse),
    .request       (request),
    .arrival_cnt   (arrival_cnt),
    .fault         (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  exp_t exp_q[$];

  // Reference model state (behavioural, per channel)
  logic [1:0]  pipe   [N_CH];  // [0]: input seen one edge ago, [1]: two edges ago
  logic [FL:0] hist   [N_CH];  // last FL+1 samples that reached the filter
  logic        m_stab [N_CH];
  logic        m_on   [N_CH];
  logic        m_flt  [N_CH];
  logic        m_req  [N_CH];
  int          m_oncyc[N_CH];  // edges spent present so far
  int          m_cnt  [N_CH];
  int          rnd_hold[N_CH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model over the next rising edge using the inputs now driven
  task automatic model_step();
    exp_t e;
    e = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (rst) begin
        pipe[c]    = '0;
        hist[c]    = '0;
        m_stab[c]  = 1'b0;
        m_on[c]    = 1'b0;
        m_flt[c]   = 1'b0;
        m_req[c]   = 1'b0;
        m_oncyc[c] = 0;
        m_cnt[c]   = 0;
      end else begin
        logic n, dlv, st_old, pulse, enter;
        n      = sensor_raw[c] ^ MASK[c];
        dlv    = pipe[c][1];
        pipe[c] = {pipe[c][0], n};
        st_old = m_stab[c];
        pulse  = 1'b0;
        enter  = 1'b0;
        // Occupancy decisions use the debounced level from before this edge
        if (m_flt[c]) begin
          if (!st_old) m_flt[c] = 1'b0;
        end else if (m_on[c]) begin
          if (!st_old) begin
            m_on[c] = 1'b0;
          end else if (m_oncyc[c] == SL) begin
            m_on[c]  = 1'b0;
            m_flt[c] = 1'b1;
            enter    = 1'b1;
          end else begin
            m_oncyc[c]++;
          end
        end else if (st_old) begin
          m_on[c]    = 1'b1;
          m_oncyc[c] = 1;
          pulse      = 1'b1;
        end
        // Debounced level flips once FL+1 consecutive filter samples disagree
        hist[c] = {hist[c][FL-1:0], dlv};
        if (hist[c] == {(FL+1){~st_old}}) m_stab[c] = ~st_old;
        if (enter) m_req[c] = 1'b0;
        else if (pulse) m_req[c] = 1'b1;
        else if (req_clr[c]) m_req[c] = 1'b0;
        if (cnt_clr) m_cnt[c] = pulse ? 1 : 0;
        else if (pulse && m_cnt[c] < CNT_MAX) m_cnt[c]++;
        e.pulse[c] = pulse;
      end
      e.present[c]         = m_on[c];
      e.request[c]         = m_req[c];
      e.fault[c]           = m_flt[c];
      e.cnt[c*CW +: CW]    = CW'(m_cnt[c]);
    end
    exp_q.push_back(e);
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_ch(input int c, input logic active);
    sensor_raw[c] = active ^ MASK[c];
  endtask

  // Monitor: one expected entry per rising edge, sampled just after it
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("present",       32'(present),       32'(e.present));
      check("arrival_pulse", 32'(arrival_pulse), 32'(e.pulse));
      check("request",       32'(request),       32'(e.request));
      check("fault",         32'(fault),         32'(e.fault));
      check("arrival_cnt",   32'(arrival_cnt),   32'(e.cnt));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    sensor_raw = MASK;  // all channels idle
    req_clr    = '0;
    cnt_clr    = 1'b0;
    ticks(3);
    rst = 1'b0;
    ticks(4);

    // Ch0 active-low arrival, then release
    set_ch(0, 1'b1);
    ticks(12);
    set_ch(0, 1'b0);
    ticks(10);

    // Ch1: 3-cycle glitch is rejected, 4-cycle pulse is accepted
    set_ch(1, 1'b1);
    ticks(3);
    set_ch(1, 1'b0);
    ticks(8);
    set_ch(1, 1'b1);
    ticks(4);
    set_ch(1, 1'b0);
    ticks(12);

    // Ch2 is active-high under this mask
    set_ch(2, 1'b1);
    ticks(10);
    set_ch(2, 1'b0);
    ticks(10);

    // Clear ch0 request, then req_clr lands on the arrival edge, then alone
    req_clr[0] = 1'b1;
    tick();
    req_clr[0] = 1'b0;
    set_ch(0, 1'b1);
    ticks(FL + 3);
    req_clr[0] = 1'b1;
    tick();
    tick();
    req_clr[0] = 1'b0;
    ticks(3);
    set_ch(0, 1'b0);
    ticks(10);

    // Ch3 stuck occupied, then released
    set_ch(3, 1'b1);
    ticks(65);
    set_ch(3, 1'b0);
    ticks(12);

    // 20 arrivals on ch0 saturate the counter
    for (int k = 0; k < 20; k++) begin
      set_ch(0, 1'b1);
      ticks(5);
      set_ch(0, 1'b0);
      ticks(5);
    end
    ticks(3);

    // cnt_clr alone, then cnt_clr coincident with an arrival
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    set_ch(0, 1'b1);
    ticks(FL + 3);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    ticks(3);
    set_ch(0, 1'b0);
    ticks(10);

    // Reset asserted mid-debounce on ch1; sensor stays active across release
    set_ch(1, 1'b1);
    ticks(4);
    rst = 1'b1;
    #1;
    check("rst_present", 32'(present),       32'd0);
    check("rst_pulse",   32'(arrival_pulse), 32'd0);
    check("rst_request", 32'(request),       32'd0);
    check("rst_fault",   32'(fault),         32'd0);
    check("rst_cnt",     32'(arrival_cnt),   32'd0);
    ticks(2);
    rst = 1'b0;
    ticks(15);
    set_ch(1, 1'b0);
    ticks(10);

    // Randomised hold times, clears and counter clears on all channels
    for (int c = 0; c < N_CH; c++) rnd_hold[c] = $urandom_range(0, 8);
    for (int t = 0; t < 500; t++) begin
      for (int c = 0; c < N_CH; c++) begin
        if (rnd_hold[c] == 0) begin
          sensor_raw[c] = ~sensor_raw[c];
          rnd_hold[c]   = $urandom_range(1, 9);
        end else begin
          rnd_hold[c]--;
        end
      end
      req_clr = ($urandom_range(0, 7) == 0) ? N_CH'($urandom) : '0;
      cnt_clr = ($urandom_range(0, 31) == 0);
      tick();
    end
    req_clr = '0;
    cnt_clr = 1'b0;
    ticks(2);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sensor_array_input.md
Name: sensor_array_input

Overview:
Multi-channel vehicle-detector front end for the traffic light sequencer. Each channel synchronises, normalises polarity and debounces a raw loop/button sensor, then produces:
- a level "present" output
- a one-cycle arrival pulse
- a sticky service request, cleared by the sequencer
- a saturating arrival count

A per-channel stuck-sensor watchdog flags and masks any sensor that stays occupied too long. The block sits between the pad inputs and the phase controller FSM.

Parameters:
- N_CH, 4: number of sensor channels (1..16).
- ACTIVE_LOW_MASK, {N_CH{1'b1}}: bit i = 1 means channel i raw input is active-low.
- FILTER_LIMIT, 10: debounce threshold; a change commits after FILTER_LIMIT+1 consecutive mismatching cycles.
- STUCK_LIMIT, 100000: cycles of continuous debounced presence before channel faults.
- CNT_W, 8: width of each arrival counter.

Ports:
- clk, in, 1: clock.
- rst, in, 1: reset; asynchronous, active-high.
- sensor_raw, in, N_CH: raw asynchronous sensor inputs.
- req_clr, in, N_CH: per-channel request clear strobe from sequencer.
- cnt_clr, in, 1: clears all arrival counters.
- present, out, N_CH: debounced occupancy; forced 0 while faulted.
- arrival_pulse, out, N_CH: 1-cycle pulse on debounced rising edge.
- request, out, N_CH: sticky service request.
- arrival_cnt, out, N_CH*CNT_W: packed counters, channel i at [i*CNT_W +: CNT_W].
- fault, out, N_CH: stuck-sensor flag.

Behaviour:
- Reset: all sync flops, debounce counters, stuck timers and counters go to 0. State is S_OFF. Every output is 0.
- Normalise: norm[i] = sensor_raw[i] XOR ACTIVE_LOW_MASK[i], applied before synchronisation.
- Sync: 2-flop synchroniser per channel gives sync[i].
- Debounce (internal stable[i]):
  - If sync != stable and dcnt < FILTER_LIMIT, then dcnt++.
  - If sync != stable and dcnt == FILTER_LIMIT, then stable <= sync and dcnt <= 0.
  - If sync == stable, then dcnt <= 0.
  - Latency: raw edge set up before clock edge k gives stable updated at edge k+2+FILTER_LIMIT. That is FILTER_LIMIT+3 edges, so 13 at default.
  - Any glitch lasting ≤ FILTER_LIMIT synchronised cycles is rejected.
- Per-channel FSM, states S_OFF, S_ON, S_FAULT:
  - S_OFF -> S_ON on stable rise. arrival_pulse = 1 for exactly that cycle; stuck timer <= 0.
  - S_ON -> S_OFF on stable fall.
  - S_ON -> S_FAULT when stuck timer reaches STUCK_LIMIT-1 while stable is still 1. On entry, fault = 1 and request is cleared.
  - S_FAULT -> S_OFF on stable fall, with fault = 0. No arrival pulse is generated while in S_FAULT.
  - present = (state == S_ON). The stuck timer counts only in S_ON. Its width is $clog2(STUCK_LIMIT+1) and it saturates.
- Request:
  - Set on arrival_pulse, cleared on req_clr.
  - Simultaneous arrival_pulse and req_clr: set wins.
  - Entry to S_FAULT: clear wins over everything.
- Counter:
  - Increments on arrival_pulse and saturates at 2^CNT_W-1.
  - cnt_clr alone: count goes to 0.
  - cnt_clr together with arrival_pulse: count goes to 1.
- Registered outputs: all outputs come from registers; no combinational path from input to output.
- Reset mid-operation: asynchronous, returns every state immediately. No pulse is emitted on reset release even if the sensor is active; a new arrival needs FILTER_LIMIT+3 edges.

Decomposition:
- Shared package sensor_pkg holds:
  - the state encoding typedef (S_OFF=2'd0, S_ON=2'd1, S_FAULT=2'd2)
  - the default FILTER_LIMIT and STUCK_LIMIT constants
  - a function for the counter slice index
- Sub-module sensor_channel covers one channel: sync, debounce, FSM, request, counter, with polarity as a 1-bit parameter. The top level generates N_CH instances and packs the outputs.

Test Plan:
Test parameters: N_CH=4, FILTER_LIMIT=3, STUCK_LIMIT=50, CNT_W=4.

1. Ch0 active-low, sensor_raw[0] driven 1->0 before edge 10 -> present[0] and arrival_pulse[0] rise after edge 16; pulse width 1 cycle; request[0] = 1; arrival_cnt ch0 = 1.
2. Ch1 raw low pulse of 3 cycles, then a 4-cycle pulse -> 3-cycle pulse gives no present change; 4-cycle pulse gives present[1] = 1 once.
3. ACTIVE_LOW_MASK=4'b1011, ch2 driven high -> detected as active-high; ch2 arrival recorded; other channels unaffected.
4. Ch0 req_clr asserted in the same cycle as a new arrival_pulse -> request[0] stays 1. req_clr alone the next cycle -> request[0] = 0.
5. Ch3 held occupied 60 cycles -> fault[3] = 1 and present[3] = 0 after 50 cycles in S_ON, with request[3] cleared. Release -> fault[3] = 0 after FILTER_LIMIT+3 edges, with no arrival pulse.
6. 20 arrivals on ch0 -> count saturates at 15. cnt_clr coincident with an arrival -> count = 1. rst asserted mid-debounce (dcnt = 2) -> all outputs 0 at once; no pulse follows reset release.
